// File: rtl/bank_pkg.sv
// Shared constants and types for the bank read streamer.
// Holds the default bank geometry, the streamer FSM state encoding and a
// small helper used to compute how many words are held or on their way.
package bank_pkg;

    // Default bank geometry: 1024 words of 8 bits.
    localparam int A_WID_DEF = 10;
    localparam int D_WID_DEF = 8;

    // The output buffer holds at most this many words, counting the word
    // that is still travelling back from the bank.
    localparam int FIFO_DEPTH = 2;

    // Streamer control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } stream_state_t;

    // Words buffered plus the one read still in flight from the bank.
    function automatic logic [2:0] occupancy(input logic [1:0] count,
                                             input logic       inflight);
        return {1'b0, count} + {2'b00, inflight};
    endfunction

endpackage

// File: rtl/skid_fifo.sv
// Two-entry FIFO that catches bank read data the consumer has not yet taken.
// Push and pop may happen in the same cycle; a push to a full FIFO or a pop
// from an empty one is ignored so the pointers can never be corrupted.
module skid_fifo
    import bank_pkg::*;
#(
    parameter int D_WID = D_WID_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [D_WID-1:0] wdata,
    input  logic             pop,
    output logic [D_WID-1:0] rdata,
    output logic [1:0]       count,
    output logic             full,
    output logic             empty
);

    logic [D_WID-1:0] mem_q [FIFO_DEPTH];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == 2'(FIFO_DEPTH));
    assign empty   = (count_q == 2'd0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_ok) wr_ptr_q <= ~wr_ptr_q;
            if (pop_ok)  rd_ptr_q <= ~rd_ptr_q;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Word storage.
    // NOTE: storage is deliberately not reset; the cleared count marks every
    // slot empty and nothing reads a slot before it has been written.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/bank_read_streamer.sv
// Streams a contiguous run of words out of a single-port read bank.
// A job is (base_addr, len); reads are issued at base_addr+k with natural
// wrap-around, and the returned words leave on a valid/ready stream with
// out_last on the final word. Reads are only issued while there is room for
// the returned word, so back-pressure never loses or duplicates data. A word
// arriving from the bank is presented on the stream in the cycle it arrives
// (bypassing the FIFO) and is only parked in the FIFO if it is not taken.
module bank_read_streamer
    import bank_pkg::*;
#(
    parameter int A_WID = A_WID_DEF,
    parameter int D_WID = D_WID_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [A_WID-1:0] base_addr,
    input  logic [A_WID:0]   len,
    output logic             busy,
    output logic             done,
    output logic             mem_en,
    output logic [A_WID-1:0] mem_addr,
    input  logic [D_WID-1:0] mem_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [D_WID-1:0] out_data,
    output logic             out_last
);

    localparam int CW = A_WID + 1;

    stream_state_t    state_q;
    logic [A_WID-1:0] addr_q;
    logic [CW-1:0]    len_q;
    logic [CW-1:0]    issue_cnt_q;
    logic [CW-1:0]    beat_cnt_q;
    logic             inflight_q;
    logic             busy_q;
    logic             done_q;

    logic [CW-1:0]    len_m1;
    logic             pop;
    logic [2:0]       occ;
    logic             fifo_push;
    logic             fifo_pop;
    logic [D_WID-1:0] fifo_rdata;
    logic [1:0]       fifo_count;
    logic             fifo_full;
    logic             fifo_empty;

    assign len_m1    = len_q - CW'(1);
    assign out_valid = ~fifo_empty | inflight_q;
    assign pop       = out_valid & out_ready;
    assign out_last  = out_valid & (beat_cnt_q == len_m1);
    assign occ       = occupancy(fifo_count, inflight_q);

    // A read may go out only if its word will have a slot once this cycle's
    // handshake (if any) has freed one.
    assign mem_en    = (state_q == ST_RUN) & (occ < (3'd2 + {2'b00, pop}));
    assign mem_addr  = addr_q;

    // The arriving word is parked unless it is handed straight to the
    // consumer. The full guard never blocks in practice: the slot check
    // above keeps a free entry for every read in flight.
    assign fifo_push = inflight_q & ~(pop & fifo_empty) & ~fifo_full;
    assign fifo_pop  = pop & ~fifo_empty;

    assign busy      = busy_q;
    assign done      = done_q;

    skid_fifo #(
        .D_WID (D_WID)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (mem_rdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Stream word select: oldest buffered word first, else the bank word
    // arriving this cycle, else zero so an idle stream shows no stale data.
    // NOTE: out_data gets a default before any branch so the block stays
    // purely combinational and no latch is inferred.
    always_comb begin
        out_data = '0;
        if (!fifo_empty) begin
            out_data = fifo_rdata;
        end else if (inflight_q) begin
            out_data = mem_rdata;
        end
    end

    // Job control: accepts jobs, walks the address, counts beats and raises
    // the registered busy/done flags.
    // NOTE: every register here is written with <= so all of them see the
    // values from before the edge, whatever order the statements are in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            issue_cnt_q <= '0;
            beat_cnt_q  <= '0;
            inflight_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            inflight_q <= mem_en;
            done_q     <= 1'b0;
            if (pop) beat_cnt_q <= beat_cnt_q + CW'(1);

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            addr_q      <= base_addr;
                            len_q       <= len;
                            issue_cnt_q <= '0;
                            beat_cnt_q  <= '0;
                            busy_q      <= 1'b1;
                            state_q     <= ST_RUN;
                        end else begin
                            // Empty job: nothing to read, just acknowledge.
                            done_q <= 1'b1;
                        end
                    end
                end

                ST_RUN: begin
                    if (mem_en) begin
                        addr_q      <= addr_q + A_WID'(1);
                        issue_cnt_q <= issue_cnt_q + CW'(1);
                        if (issue_cnt_q == len_m1) state_q <= ST_DRAIN;
                    end
                end

                ST_DRAIN: begin
                    if (pop && out_last) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bank_read_streamer.sv
// Directed testbench for bank_read_streamer with a behavioural 1024x8 bank
// preloaded with mem[i] = i[7:0]. Inputs change on the falling edge and
// outputs are sampled 1 time unit later, mid-cycle.
module tb_bank_read_streamer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  base_addr;
    logic [10:0] len;
    logic        busy;
    logic        done;
    logic        mem_en;
    logic [9:0]  mem_addr;
    logic [7:0]  mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;

    int checks = 0;
    int errors = 0;

    logic [7:0] bank [1024];

    bank_read_streamer #(
        .A_WID (10),
        .D_WID (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    // Bank model: registered read, data one cycle after the enable cycle.
    always @(posedge clk) begin
        mem_rdata <= mem_en ? bank[mem_addr] : 8'hEE;
    end

    // One cycle of stimulus; returns mid-cycle with outputs settled.
    task automatic drive(input logic s, input int b, input int l, input logic r);
        @(negedge clk);
        start     = s;
        base_addr = 10'(b);
        len       = 11'(l);
        out_ready = r;
        #1;
    endtask

    // Outputs with address/data masked when their qualifier is low.
    function automatic logic [22:0] snap();
        return {busy, done, mem_en, (mem_en ? mem_addr : 10'h0),
                out_valid, out_last, (out_valid ? out_data : 8'h0)};
    endfunction

    // Every output raw, for the reset checks.
    function automatic logic [22:0] raw_outs();
        return {busy, done, mem_en, mem_addr, out_valid, out_last, out_data};
    endfunction

    // Job with out_ready held high; optional stray start at cycle spur_c.
    task automatic run_full(input string name, input int base, input int l,
                            input int spur_c);
        logic [22:0] exp_v;
        logic [22:0] got_v;
        logic        e_busy, e_done, e_en, e_valid, e_last;
        logic [9:0]  e_addr;
        logic [7:0]  e_data;
        for (int c = 0; c <= l + 4; c++) begin
            if (c == 0)           drive(1'b1, base, l, 1'b1);
            else if (c == spur_c) drive(1'b1, base ^ 10'h080, 2, 1'b1);
            else                  drive(1'b0, 0, 0, 1'b1);
            e_busy  = (c >= 1) && (c <= l + 1);
            e_done  = (c == l + 2);
            e_en    = (c >= 1) && (c <= l);
            e_addr  = e_en ? 10'(base + c - 1) : 10'h0;
            e_valid = (c >= 2) && (c <= l + 1);
            e_last  = (c == l + 1);
            e_data  = e_valid ? 8'(base + c - 2) : 8'h0;
            exp_v   = {e_busy, e_done, e_en, e_addr, e_valid, e_last, e_data};
            got_v   = snap();
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL %s cycle %0d: got %h expected %h", name, c, got_v, exp_v);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 5, 3, 1'b1);
        checks++;
        if (raw_outs() !== 23'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", raw_outs());
        end
        drive(1'b0, 0, 0, 1'b0);
        checks++;
        if (raw_outs() !== 23'h0) begin
            errors++;
            $display("FAIL reset_outputs_hold: got %h expected 0", raw_outs());
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        run_full("basic_base4_len3", 4, 3, -1);
    endtask

    task automatic test_wrap();
        run_full("wrap_base3fe_len4", 10'h3FE, 4, -1);
    endtask

    task automatic test_zero_len();
        logic [2:0] exp_v;
        for (int c = 0; c <= 3; c++) begin
            drive(c == 0, 7, 0, 1'b1);
            exp_v = {1'b0, (c == 1), 1'b0};
            checks++;
            if ({busy, done, mem_en} !== exp_v) begin
                errors++;
                $display("FAIL zero_len cycle %0d: busy/done/mem_en got %b expected %b",
                         c, {busy, done, mem_en}, exp_v);
            end
        end
    endtask

    // out_ready pattern 1,0,0,1 repeating; checks order, slot limit, stability.
    task automatic test_stall();
        int         issued = 0;
        int         accepted = 0;
        bit         seen_done = 0;
        logic       prev_stall = 1'b0;
        logic [7:0] prev_data = 8'h0;
        logic       prev_last = 1'b0;
        logic       r;
        logic       p;
        for (int c = 0; c < 200 && !seen_done; c++) begin
            r = ((c % 4) == 0) || ((c % 4) == 3);
            drive(c == 0, 10'h010, 8, r);
            p = out_valid & out_ready;
            if (mem_en) begin
                checks++;
                if ((issued - accepted - int'(p)) >= 2 || mem_addr !== 10'(10'h010 + issued)) begin
                    errors++;
                    $display("FAIL stall_issue cycle %0d: addr %h held %0d pop %0d expected addr %h with room",
                             c, mem_addr, issued - accepted, p, 10'(10'h010 + issued));
                end
                issued++;
            end
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
                    errors++;
                    $display("FAIL stall_hold cycle %0d: got v%b d%h l%b expected v1 d%h l%b",
                             c, out_valid, out_data, out_last, prev_data, prev_last);
                end
            end
            if (p) begin
                checks++;
                if (out_data !== 8'(8'h10 + accepted) || out_last !== (accepted == 7)) begin
                    errors++;
                    $display("FAIL stall_beat %0d: got d%h l%b expected d%h l%b",
                             accepted, out_data, out_last, 8'(8'h10 + accepted), (accepted == 7));
                end
                accepted++;
            end
            if (done) begin
                seen_done = 1;
                checks++;
                if (accepted != 8 || issued != 8 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_done: beats %0d reads %0d busy %b expected 8 8 0",
                             accepted, issued, busy);
                end
            end
            prev_stall = out_valid & ~out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
        checks++;
        if (!seen_done) begin
            errors++;
            $display("FAIL stall_timeout: done not seen, expected within 200 cycles");
        end
    endtask

    task automatic test_reset_mid_job();
        for (int c = 0; c <= 4; c++) drive(c == 0, 10'h020, 8, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h22) begin
            errors++;
            $display("FAIL midrst_beat2: got v%b d%h expected v1 d22", out_valid, out_data);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (raw_outs() !== 23'h0) begin
            errors++;
            $display("FAIL midrst_immediate: got %h expected 0", raw_outs());
        end
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 0, 0, 1'b1);
            checks++;
            if (raw_outs() !== 23'h0) begin
                errors++;
                $display("FAIL midrst_held cycle %0d: got %h expected 0", c, raw_outs());
            end
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 0, 0, 1'b1);
            checks++;
            if ({busy, done, mem_en, out_valid} !== 4'b0000) begin
                errors++;
                $display("FAIL midrst_after cycle %0d: busy/done/mem_en/valid got %b expected 0000",
                         c, {busy, done, mem_en, out_valid});
            end
        end
        run_full("restart_base0_len3", 0, 3, -1);
    endtask

    task automatic test_start_ignored();
        run_full("spurious_start_run", 10'h040, 4, 2);
        run_full("spurious_start_drain", 10'h050, 2, 3);
    endtask

    task automatic test_full_bank();
        run_full("full_bank_len1024", 10'h155, 1024, -1);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) bank[i] = 8'(i);
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        len       = '0;
        out_ready = 1'b0;

        test_reset();
        test_basic();
        test_wrap();
        test_zero_len();
        test_stall();
        test_reset_mid_job();
        test_start_ignored();
        test_full_bank();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bank_read_streamer.md
BANK_READ_STREAMER -- requirements
Module: bank_read_streamer

Interface
REQ-001 SHALL have parameter A_WID, default 10, meaning the bank address width in bits.
REQ-002 SHALL have parameter D_WID, default 8, meaning the bank data word width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: single-cycle job request.
REQ-006 SHALL have port base_addr, input, A_WID bits: first bank address of the job.
REQ-007 SHALL have port len, input, A_WID+1 bits: number of words in the job, 0..2**A_WID.
REQ-008 SHALL have port busy, output, 1 bit: high while a job is active.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when a job completes.
REQ-010 SHALL have port mem_en, output, 1 bit: bank port enable, with write enable tied low externally.
REQ-011 SHALL have port mem_addr, output, A_WID bits: bank read address.
REQ-012 SHALL have port mem_rdata, input, D_WID bits: bank read data, valid exactly one cycle after the mem_en cycle.
REQ-013 SHALL have port out_valid, output, 1 bit: output stream beat valid.
REQ-014 SHALL have port out_ready, input, 1 bit: consumer accepts the beat.
REQ-015 SHALL have port out_data, output, D_WID bits: stream word.
REQ-016 SHALL have port out_last, output, 1 bit: marks the final beat of the job.

Function
REQ-017 SHALL implement FSM states IDLE, RUN and DRAIN.
REQ-018 SHALL, in IDLE with start=1 and len>0, latch base_addr and len and enter RUN next cycle.
REQ-019 SHALL, in IDLE with start=1 and len=0, issue no reads, hold busy low, and pulse done on the following cycle.
REQ-020 SHALL ignore start while busy=1.
REQ-021 SHALL, in RUN, issue read k (k=0..len-1) at address (base_addr+k) mod 2**A_WID, so the address wraps from 2**A_WID-1 to 0.
REQ-022 SHALL assert mem_en only for an issued read, and only when (fifo_count + inflight - pop) < 2, where pop = out_valid & out_ready in the same cycle.
REQ-023 SHALL capture mem_rdata into a 2-entry FIFO on the cycle after each issued read.
REQ-024 SHALL sustain one beat per cycle when out_ready is held high, after a 2-cycle start-to-first-valid latency (start at cycle 0, out_valid at cycle 2).
REQ-025 SHALL enter DRAIN once the last read is issued, and return to IDLE when the beat with out_last is handshaken.
REQ-026 SHALL assert out_last together with out_valid only on beat len-1.
REQ-027 SHALL hold out_data, out_last and out_valid stable while out_valid=1 and out_ready=0.
REQ-028 SHALL pulse done in the cycle after the last-beat handshake, with busy falling in that same cycle.
REQ-029 SHALL assert busy from the cycle after an accepted start until the done cycle, exclusive of the done cycle.
REQ-030 SHALL never overflow the FIFO and never lose or duplicate a word under any out_ready pattern.
REQ-031 SHALL handle len=2**A_WID by reading every bank address exactly once, starting at base_addr.

Reset
REQ-032 SHALL, while rst=1, force the state to IDLE and clear the FIFO, counters and inflight flag.
REQ-033 SHALL, while rst=1, drive busy=0, done=0, mem_en=0, mem_addr=0, out_valid=0, out_last=0 and out_data=0.
REQ-034 SHALL, when rst is asserted mid-job, abandon the job with no done pulse; read data returned after reset SHALL be discarded.

Structure
REQ-035 SHALL take the default A_WID/D_WID constants and the streamer state enum from shared package bank_pkg.
REQ-036 SHALL place the 2-entry FIFO in sub-module skid_fifo, parameterised by D_WID, with push, pop, count, full and empty.
REQ-037 SHALL be within 120-400 lines of RTL in total.

Verification
REQ-038 SHALL verify: bank preloaded mem[i]=i, start with base=4, len=3, out_ready=1 -> beats 04, 05, 06 on cycles 2-4, last on 06, done on cycle 5.
REQ-039 SHALL verify: base=0x3FE, len=4 -> addresses 3FE, 3FF, 000, 001 and matching data.
REQ-040 SHALL verify: len=0 -> no mem_en, busy stays 0, done one cycle after start.
REQ-041 SHALL verify: len=8 with out_ready toggling 1,0,0,1 repeatedly -> 8 in-order beats, no mem_en while the FIFO plus inflight is full, out_data stable during stalls.
REQ-042 SHALL verify: rst asserted after beat 2 of len=8 -> all outputs 0 immediately, no done; a new job starting at base=0 then streams correctly.
REQ-043 SHALL verify: start pulsed during an active job -> ignored, and the current job completes unchanged.
